pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Instruction-fetch stage. Holds the PC, issues one instruction
//            memory request at a time (valid/ready), and offers
//            {pc, pc+4, instr} to decode (valid/ready). A taken branch or
//            jump (branch_or_not) redirects the PC and squashes any younger
//            instruction still in flight.
// Ports    : clk, rst_n (sync, active-low)
//            branch_or_not, branch_target      - redirect from branch logic
//            imem_req_valid/ready/addr         - fetch request channel
//            imem_rsp_valid/data               - fetch response
//            if_valid/ready, if_pc, if_pc_plus4, if_instr - decode channel
//            misalign_err                      - misaligned-target pulse
// Options  : `define FETCH_MISALIGN_CHECK_EN to reject redirects whose
//            target has nonzero low two bits (pulses misalign_err and keeps
//            fetching sequentially). Undefined: low target bits are cleared
//            and misalign_err stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch_or_not,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [31:0]     if_instr,
  output logic            misalign_err
);

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ptgt;   // redirect target parked while a request waits for acceptance
  logic            pend;   // ptgt is valid and must be applied on acceptance
  logic            drop;   // the outstanding response belongs to a squashed path

  logic            redir;
  logic            mis;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_plus4;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign mis   = branch_or_not && (branch_target[1:0] != 2'b00);
  assign redir = branch_or_not && !mis;
  assign tgt   = branch_target;
`else
  assign mis   = 1'b0;
  assign redir = branch_or_not;
  assign tgt   = branch_target & ~LOW_MASK;
`endif

  // Wraps modulo 2^XLEN by construction.
  assign pc_plus4 = pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      ptgt           <= '0;
      pend           <= 1'b0;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      if_valid       <= 1'b0;
      if_pc          <= '0;
      if_pc_plus4    <= '0;
      if_instr       <= '0;
      misalign_err   <= 1'b0;
    end else begin
      misalign_err <= mis;
      case (state)
        S_IDLE: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b1;
          if (redir) begin
            pc            <= tgt;
            imem_req_addr <= tgt;
          end else begin
            imem_req_addr <= pc;
          end
        end

        S_REQ: begin
          if (imem_req_ready) begin
            // The accepted address is now stale if any redirect arrived
            // while it was pending; its response must be discarded.
            imem_req_valid <= 1'b0;
            state          <= S_WAIT;
            pend           <= 1'b0;
            if (redir) begin
              pc   <= tgt;
              drop <= 1'b1;
            end else if (pend) begin
              pc   <= ptgt;
              drop <= 1'b1;
            end
          end else if (redir) begin
            // Address must stay stable until accepted; park the target.
            pend <= 1'b1;
            ptgt <= tgt;
          end
        end

        S_WAIT: begin
          if (redir) begin
            pc <= tgt;
            if (imem_rsp_valid) begin
              // Stale word arrives in the same cycle: discard it directly.
              drop           <= 1'b0;
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
              imem_req_addr  <= tgt;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop) begin
              drop           <= 1'b0;
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
              imem_req_addr  <= pc;
            end else begin
              if_instr    <= imem_rsp_data;
              if_pc       <= pc;
              if_pc_plus4 <= pc_plus4;
              if_valid    <= 1'b1;
              state       <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          // A redirect wins over a simultaneous if_ready: decode squashes
          // the offered instruction on the same branch_or_not.
          if (redir) begin
            pc             <= tgt;
            if_valid       <= 1'b0;
            state          <= S_REQ;
            imem_req_valid <= 1'b1;
            imem_req_addr  <= tgt;
          end else if (if_ready) begin
            pc             <= pc_plus4;
            if_valid       <= 1'b0;
            state          <= S_REQ;
            imem_req_valid <= 1'b1;
            imem_req_addr  <= pc_plus4;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit. A small memory responder
//            and a decode model run inside the per-cycle tick task; expected
//            request addresses and decode handoffs are queued as the
//            directed stimulus is written and compared as the DUT produces
//            them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        branch_or_not;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        misalign_err;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_or_not  (branch_or_not),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ins;
  } out_t;

  logic [31:0] exp_addr[$];
  out_t        exp_out[$];
  int          hs_cyc[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          hs_n  = 0;
  int          rsp_cnt = 0;
  int          rsp_delay = 1;
  logic [31:0] rsp_word = 32'h0000_0013;
  logic [31:0] cur_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then act as memory and decode.
  task automatic tick();
    logic        acc, hs;
    logic [31:0] a;
    out_t        got, want;
    acc = rst_n && imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    hs  = rst_n && if_valid && if_ready && !branch_or_not;
    got = '{pc: if_pc, pc4: if_pc_plus4, ins: if_instr};
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      total++;
      assert (exp_addr.size() != 0) else begin
        bad++;
        $error("FAIL req_extra: observed addr=%h expected=none", a);
      end
      if (exp_addr.size() != 0) check("req_addr", a, exp_addr.pop_front());
      rsp_cnt = rsp_delay;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = rsp_word;
      end
    end
    if (hs) begin
      hs_n++;
      hs_cyc.push_back(cyc);
      total++;
      assert (exp_out.size() != 0) else begin
        bad++;
        $error("FAIL handoff_extra: observed pc=%h expected=none", got.pc);
      end
      if (exp_out.size() != 0) begin
        want = exp_out.pop_front();
        check("if_pc", got.pc, want.pc);
        check("if_pc_plus4", got.pc4, want.pc4);
        check("if_instr", got.ins, want.ins);
      end
    end
  endtask

  task automatic wait_hs(input int target, input int budget);
    int k = 0;
    while (hs_n < target && k < budget) begin
      tick();
      k++;
    end
    check("handoff_count", 32'(hs_n), 32'(target));
  endtask

  task automatic wait_if_valid(input int budget);
    int k = 0;
    while (!if_valid && k < budget) begin
      tick();
      k++;
    end
    check("if_valid_reached", {31'd0, if_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    branch_or_not  = 1'b0;
    branch_target  = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if_ready       = 1'b1;

    // ---- reset ----
    tick();
    tick();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;
    check("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // ---- sequential fetch ----
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_addr.push_back(32'hC);
    exp_out.push_back('{pc: 32'h0, pc4: 32'h4, ins: 32'h13});
    exp_out.push_back('{pc: 32'h4, pc4: 32'h8, ins: 32'h13});
    exp_out.push_back('{pc: 32'h8, pc4: 32'hC, ins: 32'h13});
    tick();
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    wait_hs(3, 20);
    if (hs_cyc.size() >= 3) begin
      check("handoff_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      check("handoff_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
    end
    tick();                       // 0xC accepted, its response now on the bus

    // ---- reset mid-operation, stale response ignored ----
    rst_n = 1'b0;
    tick();
    check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("midrst_req_addr", imem_req_addr, 32'h0);
    check("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    rsp_word       = 32'h0010_0093;
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_addr.push_back(32'h100);
    exp_out.push_back('{pc: 32'h0, pc4: 32'h4, ins: 32'h0010_0093});
    exp_out.push_back('{pc: 32'h4, pc4: 32'h8, ins: 32'h0010_0093});
    exp_out.push_back('{pc: 32'h100, pc4: 32'h104, ins: 32'h0010_0093});
    tick();
    check("rerun_req_addr", imem_req_addr, 32'h0);
    wait_hs(5, 20);

    // ---- backpressure at pc 0x8, with a stray response in HOLD ----
    if_ready = 1'b0;
    wait_if_valid(10);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBADB_AD00;
      end
      tick();
      check("bp_if_valid", {31'd0, if_valid}, 32'd1);
      check("bp_if_pc", if_pc, 32'h8);
      check("bp_if_pc_plus4", if_pc_plus4, 32'hC);
      check("bp_if_instr", if_instr, 32'h0010_0093);
      check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end

    // ---- redirect in HOLD, overriding a simultaneous if_ready ----
    if_ready      = 1'b1;
    branch_or_not = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_or_not = 1'b0;
    check("hold_redir_if_valid", {31'd0, if_valid}, 32'd0);
    check("hold_redir_req_addr", imem_req_addr, 32'h100);
    wait_hs(6, 10);

    // ---- redirect in WAIT, stale response arrives 3 cycles later ----
    exp_addr.push_back(32'h104);
    exp_addr.push_back(32'h200);
    rsp_delay = 3;
    rsp_word  = 32'hDEAD_BEEF;
    tick();                       // 0x104 accepted
    branch_or_not = 1'b1;
    branch_target = 32'h200;
    tick();
    branch_or_not = 1'b0;
    tick();
    tick();                       // stale word consumed here
    check("wait_redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("wait_redir_req_addr", imem_req_addr, 32'h200);
    check("wait_redir_if_valid", {31'd0, if_valid}, 32'd0);
    rsp_delay = 1;
    rsp_word  = 32'h0000_0293;
    exp_out.push_back('{pc: 32'h200, pc4: 32'h204, ins: 32'h0000_0293});
    wait_hs(7, 10);

    // ---- back-to-back redirects in REQ while not accepted ----
    imem_req_ready = 1'b0;
    exp_addr.push_back(32'h204);
    exp_addr.push_back(32'h300);
    exp_out.push_back('{pc: 32'h300, pc4: 32'h304, ins: 32'h0000_0313});
    branch_or_not = 1'b1;
    branch_target = 32'h2F0;
    tick();
    check("req_stall_addr1", imem_req_addr, 32'h204);
    branch_target = 32'h300;
    tick();
    branch_or_not = 1'b0;
    check("req_stall_addr2", imem_req_addr, 32'h204);
    tick();
    tick();
    check("req_stall_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req_stall_addr4", imem_req_addr, 32'h204);
    rsp_word       = 32'h1111_1111;
    imem_req_ready = 1'b1;
    tick();                       // 0x204 accepted, response on the bus
    rsp_word = 32'h0000_0313;
    tick();
    check("req_redir_req_addr", imem_req_addr, 32'h300);
    wait_hs(8, 10);

    // ---- redirect in REQ accepted the same cycle, then hold at 0x10 ----
    exp_addr.push_back(32'h304);
    exp_addr.push_back(32'h10);
    rsp_word      = 32'h2222_2222;
    branch_or_not = 1'b1;
    branch_target = 32'h10;
    if_ready      = 1'b0;
    tick();
    branch_or_not = 1'b0;
    rsp_word      = 32'h0000_0413;
    wait_if_valid(12);
    check("hold10_if_pc", if_pc, 32'h10);
    check("hold10_if_instr", if_instr, 32'h0000_0413);

    // ---- misaligned target 0x102 ----
    branch_or_not = 1'b1;
    branch_target = 32'h102;
    tick();
    branch_or_not = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_err_pulse", {31'd0, misalign_err}, 32'd1);
    check("mis_if_valid", {31'd0, if_valid}, 32'd1);
    check("mis_if_pc", if_pc, 32'h10);
    tick();
    check("mis_err_clear", {31'd0, misalign_err}, 32'd0);
    exp_out.push_back('{pc: 32'h10, pc4: 32'h14, ins: 32'h0000_0413});
    if_ready = 1'b1;
    wait_hs(9, 10);
    check("mis_next_addr", imem_req_addr, 32'h14);
    cur_pc = 32'h14;
`else
    check("mis_err_zero", {31'd0, misalign_err}, 32'd0);
    check("mis_if_valid", {31'd0, if_valid}, 32'd0);
    check("mis_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("mis_next_addr", imem_req_addr, 32'h100);
    exp_addr.push_back(32'h100);
    exp_out.push_back('{pc: 32'h100, pc4: 32'h104, ins: 32'h0000_0413});
    if_ready = 1'b1;
    wait_hs(9, 10);
    cur_pc = 32'h104;
`endif

    // ---- wrap of pc+4 at the top of the address space ----
    exp_addr.push_back(cur_pc);
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_out.push_back('{pc: 32'hFFFF_FFFC, pc4: 32'h0, ins: 32'h0000_0513});
    rsp_word      = 32'h3333_3333;
    branch_or_not = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_or_not = 1'b0;
    rsp_word      = 32'h0000_0513;
    wait_hs(10, 12);
    check("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("wrap_req_addr", imem_req_addr, 32'h0);

    check("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    check("out_queue_empty", 32'(exp_out.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
